// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: receives a length-prefixed, XOR-checksummed image,
// writes it into instruction memory as little-endian words, then releases the CPU.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   // state    | meaning
   // S_INIT   | one idle cycle after reset, not ready
   // S_LEN_LO | waiting for word-count low byte
   // S_LEN_HI | waiting for word-count high byte, range check
   // S_DATA   | collecting data bytes into words
   // S_CSUM   | waiting for checksum byte
   // S_RUN    | image verified, CPU released (terminal)
   // S_ERR    | image rejected, CPU held in reset (terminal)
   typedef enum logic [2:0] {
      S_INIT, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR
   } state_t;

   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

   state_t                state, state_nxt;
   logic [15:0]           count;
   logic [7:0]            csum;
   logic [1:0]            byte_idx;
   logic [ADDR_WIDTH:0]   word_idx;
   logic [23:0]           lanes;

   logic                  accept;
   logic [15:0]           len_full;
   logic                  len_over;
   logic                  last_word;

   assign accept    = rx_valid && rx_ready;
   assign len_full  = {rx_data, count[7:0]};
   assign len_over  = {1'b0, len_full} > CAPACITY;
   assign last_word = (17'(word_idx) + 17'd1) == {1'b0, count};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_reset = 1'b1;
      case (state)
         S_INIT: begin
            state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            rx_ready = 1'b1;
            if (accept) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            rx_ready = 1'b1;
            if (accept) begin
               if (len_over)              state_nxt = S_ERR;
               else if (len_full == 16'd0) state_nxt = S_CSUM;
               else                       state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            if (accept && byte_idx == 2'd3 && last_word) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            rx_ready = 1'b1;
            if (accept) state_nxt = (rx_data == csum) ? S_RUN : S_ERR;
         end
         S_RUN: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
         end
         S_ERR: begin
            error = 1'b1;
         end
         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         csum       <= '0;
         byte_idx   <= '0;
         word_idx   <= '0;
         lanes      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_LEN_LO: begin
                  count[7:0] <= rx_data;
                  csum       <= csum ^ rx_data;
               end
               S_LEN_HI: begin
                  count[15:8] <= rx_data;
                  csum        <= csum ^ rx_data;
               end
               S_DATA: begin
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: lanes[7:0]   <= rx_data;
                     2'd1: lanes[15:8]  <= rx_data;
                     2'd2: lanes[23:16] <= rx_data;
                     default: begin
                        // byte 3 completes the word; write strobe shows next cycle
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= {rx_data, lanes};
                        word_idx   <= word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
                     end
                  endcase
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: directed and random images checked against a byte-stream
// model (expected write queue plus expected terminal status).
module tb_imem_boot_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   int         errors = 0;
   int         checks = 0;
   wr_t        exp_wr[$];
   logic [7:0] stream[$];
   logic       exp_ready = 1'b0;
   logic       exp_done  = 1'b0;
   logic       exp_error = 1'b0;
   logic       prev_we   = 1'b0;
   wr_t        cur_wr;
   int         term_idx;
   bit         term_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      check("rx_ready", rx_ready, exp_ready);
      check("done", done, exp_done);
      check("error", error, exp_error);
      check("cpu_reset", cpu_reset, !exp_done);
      if (imem_we) begin
         check("we_back_to_back", prev_we, 1'b0);
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
         end else begin
            cur_wr = exp_wr.pop_front();
            check("imem_addr", imem_addr, cur_wr.addr);
            check("imem_wdata", imem_wdata, cur_wr.data);
         end
      end
      prev_we = imem_we;
   end

   task automatic check_reset_vals();
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_imem_we", imem_we, 1'b0);
      check("rst_imem_addr", imem_addr, '0);
      check("rst_imem_wdata", imem_wdata, 32'h0);
      check("rst_cpu_reset", cpu_reset, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
   endtask

   // called shortly after a rising edge; asserts reset mid-cycle
   task automatic do_reset();
      #2;
      reset = 1'b0;
      rx_valid = 1'b0;
      exp_ready = 1'b0;
      exp_done = 1'b0;
      exp_error = 1'b0;
      exp_wr.delete();
      #1;
      check_reset_vals();
      repeat (3) begin
         @(posedge clk);
         #1;
         check_reset_vals();
      end
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_ready = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      repeat (gap) begin
         rx_valid = 1'b0;
         rx_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b1;
      rx_data = b;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = rx_ready;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: byte %h not accepted, limit 50 cycles", b);
      end
   endtask

   task automatic send_stream(input int gapmode, input int nbytes);
      bit ok;
      int gap;
      for (int i = 0; i < nbytes && i < stream.size(); i++) begin
         gap = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
         send_byte(stream[i], gap, ok);
         if (!ok) return;
         if (i == term_idx) begin
            exp_ready = 1'b0;
            if (term_err) exp_error = 1'b1;
            else          exp_done = 1'b1;
            return;
         end
      end
   endtask

   task automatic offer_ignored(input int n);
      repeat (n) begin
         rx_valid = 1'b1;
         rx_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic finish_image();
      repeat (2) @(posedge clk);
      #1;
      check("pending_writes", exp_wr.size(), 0);
   endtask

   task automatic load_test2(input logic [7:0] cs);
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h40, 8'h01, cs};
      exp_wr.delete();
      exp_wr.push_back('{8'd0, 32'h00A00513});
      exp_wr.push_back('{8'd1, 32'h01400593});
      term_idx = 10;
      term_err = (cs != 8'h63);
   endtask

   task automatic build_image(input int len_field, input bit bad);
      logic [7:0]  cs;
      logic [31:0] word;
      logic [7:0]  lo;
      logic [7:0]  hi;
      stream.delete();
      exp_wr.delete();
      lo = 8'(len_field);
      hi = 8'(len_field >> 8);
      stream.push_back(lo);
      stream.push_back(hi);
      cs = lo ^ hi;
      if (len_field > (2 ** AW)) begin
         term_idx = 1;
         term_err = 1'b1;
         return;
      end
      for (int w = 0; w < len_field; w++) begin
         word = $urandom;
         for (int k = 0; k < 4; k++) begin
            stream.push_back(word[8*k +: 8]);
            cs ^= word[8*k +: 8];
         end
         exp_wr.push_back('{AW'(w), word});
      end
      if (bad) cs ^= 8'($urandom_range(1, 255));
      stream.push_back(cs);
      term_idx = stream.size() - 1;
      term_err = bad;
   endtask

   task automatic run_image(input int gapmode);
      send_stream(gapmode, stream.size());
      offer_ignored(6);
      finish_image();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bit bad;
      // reset and good image
      do_reset();
      load_test2(8'h63);
      run_image(0);
      // bad checksum
      do_reset();
      load_test2(8'h64);
      run_image(0);
      // length overflow 257
      do_reset();
      stream = '{8'h01, 8'h01};
      exp_wr.delete();
      term_idx = 1;
      term_err = 1'b1;
      run_image(0);
      // empty image
      do_reset();
      stream = '{8'h00, 8'h00, 8'h00};
      exp_wr.delete();
      term_idx = 2;
      term_err = 1'b0;
      run_image(0);
      // gapped stream
      do_reset();
      load_test2(8'h63);
      run_image(1);
      // reset mid-load after 5 bytes, then full resend
      do_reset();
      load_test2(8'h63);
      send_stream(0, 5);
      do_reset();
      load_test2(8'h63);
      run_image(0);
      // full capacity
      do_reset();
      build_image(2 ** AW, 1'b0);
      run_image(0);
      // exactly one past capacity via builder, then random images
      do_reset();
      build_image(2 ** AW + 1, 1'b0);
      run_image(2);
      for (int n = 0; n < 30; n++) begin
         do_reset();
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 65535))
                                           : int'($urandom_range(0, 6));
         bad = ($urandom_range(0, 2) == 0);
         build_image(len, bad);
         run_image(int'($urandom_range(0, 2)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-serial boot loader that sits directly upstream of `riscv_processor`. It receives a length-prefixed, checksummed program image over a valid/ready byte stream and writes it into instruction memory as 32-bit little-endian words. It holds the processor in reset until the image has been loaded and verified. On a bad image it stays in an error state and keeps the processor in reset.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `rx_data`  in  8  incoming image byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the current write.
- `imem_wdata`  out  32  word being written.
- `cpu_reset`  out  1  active-high reset to `riscv_processor`.
- `done`  out  1  image loaded and verified; processor released.
- `error`  out  1  image rejected (length overflow or checksum mismatch).

## Operation

- **Byte handshake:** a byte is accepted on a rising edge where `rx_valid && rx_ready`. `rx_data` is ignored in every other cycle.
- **Image format:** `LEN_LO`, `LEN_HI` (16-bit word count N), then 4·N data bytes (each word least-significant byte first), then one checksum byte. The checksum is the XOR of every preceding byte, including both length bytes.
- **States:** INIT, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR. Reset enters INIT.
- **INIT:** moves unconditionally to LEN_LO on the next edge. `rx_ready`=0.
- **LEN_LO:** on accept, latch `count[7:0]` and go to LEN_HI.
- **LEN_HI:** on accept, latch `count[15:8]`. Then:
  - if N > 2^ADDR_WIDTH, go to ERR;
  - else if N == 0, go to CSUM;
  - else go to DATA.
- **DATA:** a 2-bit byte index shifts each byte into its lane (byte k into bits [8k+7:8k]). On acceptance of byte 3:
  - the next cycle shows `imem_we`=1 with `imem_addr`=word index and `imem_wdata`=the assembled word;
  - the word index then increments.
  - After word N-1 is accepted, go to CSUM.
- **CSUM:** on accept, compare the byte with the running XOR. Match goes to RUN; mismatch goes to ERR.
- **RUN:** `done`=1, `cpu_reset`=0, `rx_ready`=0. Terminal until reset.
- **ERR:** `error`=1, `cpu_reset`=1, `rx_ready`=0. Terminal until reset.
- **`rx_ready`:** 1 exactly in LEN_LO, LEN_HI, DATA and CSUM. The loader never stalls for memory writes.
- **Word count N == 2^ADDR_WIDTH** is legal; the last address is 2^ADDR_WIDTH-1 and the address never wraps.
- **Bytes offered in RUN or ERR** are never accepted and have no effect.

## Timing

- **Reset values (applied immediately on `reset`=0, asynchronous):**
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_reset`=1, `done`=0, `error`=0;
  - the running XOR, count, byte index and word index are cleared.
- **`rx_ready`:** rises on the first rising edge after reset deassertion (INIT → LEN_LO).
- **Write latency:** `imem_we` is registered. It is high for exactly one cycle, starting on the edge that accepts byte 3 of a word. `imem_addr` and `imem_wdata` are stable during that cycle.
- **Back-to-back words:** with `rx_valid` held high, one word completes every 4 cycles. `imem_we` is never high on consecutive cycles.
- **Last word and checksum:** the last word's write cycle overlaps CSUM. A checksum byte may be accepted on the very next edge.
- **Release:** `done` rises and `cpu_reset` falls on the same edge that accepts a matching checksum byte. `error` rises on the edge that accepts a mismatching checksum byte, or on the edge that accepts an overflowing `LEN_HI`.
- **Reset mid-load:** aborts immediately and restores all reset values. Words already written stay in imem. A new image must restart from `LEN_LO`.

## Test plan

1. **Reset:** hold `reset`=0 for 3 cycles, then release → all outputs at reset values during reset; `rx_ready`=1 one edge after release.
2. **Good image:** send 02 00 13 05 A0 00 93 05 40 01 63 with `rx_valid` held high → two `imem_we` pulses: addr 0 = 0x00A00513, addr 1 = 0x01400593. `done`=1, `cpu_reset`=0 after the byte 0x63; `error`=0.
3. **Bad checksum:** same stream with checksum 0x64 → both writes occur, then `error`=1, `cpu_reset`=1, `done`=0, `rx_ready`=0. Further bytes are ignored.
4. **Length boundaries (ADDR_WIDTH=8):**
   - length 01 01 (257) → `error`=1 after `LEN_HI`, no `imem_we`.
   - length 00 00, checksum 00 → `done`=1 with no writes.
5. **Gapped stream:** repeat test 2 with `rx_valid` toggled every other cycle → same writes and final state.
6. **Reset mid-load:** pulse `reset` low after the 5th byte of test 2 → outputs immediately return to reset values. Resend the full stream → same result as test 2.
